// File: rtl/gate_response_checker_pkg.sv
// Shared types and constants for the gate response checker.
// Holds the FSM encoding and the standard 2-input truth tables.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } chk_state_t;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;

  localparam int TMR_W = 4;

endpackage

// File: rtl/gate_response_checker_if.sv
// Stimulus/response bundle between a gate test source and the checker.
// The master drives stimulus and samples results; the slave checks.
interface gate_chk_if #(
  parameter int N_IN = 2
);

  logic              start;
  logic              stim_valid;
  logic [N_IN-1:0]   stim;
  logic              y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              first_fail_valid;
  logic [N_IN-1:0]   first_fail_vec;
  logic              overrun;

  modport master (
    output start, stim_valid, stim, y,
    input  busy, done, pass, err_count,
    input  first_fail_valid, first_fail_vec, overrun
  );

  modport slave (
    input  start, stim_valid, stim, y,
    output busy, done, pass, err_count,
    output first_fail_valid, first_fail_vec, overrun
  );

endinterface

// File: rtl/gate_response_checker_settle_timer.sv
// Loadable down-counter with zero flag that times the DUT settle window.
// Load takes priority over decrement.
module settle_timer
  import gate_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TMR_W'(SETTLE - 1);
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Response checker: waits out the settle window after each stimulus,
// compares y with the truth table and accumulates run results.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter logic [2**N_IN-1:0]   TRUTH  = 4'b1110,
  parameter int                   SETTLE = 2
) (
  input  logic     clk,
  input  logic     rst,
  gate_chk_if.slave bus
);

  chk_state_t       r_state;
  logic [N_IN-1:0]  r_stim_q;
  logic             r_y_q;
  logic [N_IN-1:0]  r_vec_cnt;
  logic [N_IN:0]    r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_ff_valid;
  logic [N_IN-1:0]  r_ff_vec;
  logic             r_over;

  logic             w_zero;
  logic             w_load;
  logic             w_dec;
  logic             w_mis;
  logic             w_last;
  logic [N_IN:0]    w_err_nxt;

  assign w_load = (r_state == ST_ARMED) && bus.stim_valid && !bus.start;
  assign w_dec  = (r_state == ST_SETTLE);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  // y is captured as the timer expires, so CHECK compares a stable copy
  assign w_mis     = (r_y_q != TRUTH[r_stim_q]);
  assign w_err_nxt = r_err + {{N_IN{1'b0}}, w_mis};
  assign w_last    = (r_vec_cnt == {N_IN{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_stim_q   <= '0;
      r_y_q      <= 1'b0;
      r_vec_cnt  <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
      r_over     <= 1'b0;
    end else if (bus.start) begin
      r_state    <= ST_ARMED;
      r_vec_cnt  <= '0;
      r_err      <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
      r_over     <= 1'b0;
    end else begin
      if (bus.stim_valid && r_state != ST_ARMED)
        r_over <= 1'b1;
      case (r_state)
        ST_ARMED: begin
          if (bus.stim_valid) begin
            r_stim_q <= bus.stim;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            r_y_q   <= bus.y;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_err     <= w_err_nxt;
          r_vec_cnt <= r_vec_cnt + 1'b1;
          if (w_mis && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_vec   <= r_stim_q;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_state <= ST_ARMED;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_count        = r_err;
  assign bus.first_fail_valid = r_ff_valid;
  assign bus.first_fail_vec   = r_ff_vec;
  assign bus.overrun          = r_over;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed plus randomized bench for gate_response_checker (OR table,
// settle of 2) against a result-level reference model.
module tb_gate_response_checker;
  import gate_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  gate_chk_if #(.N_IN(2)) bus ();

  gate_response_checker #(
    .N_IN   (2),
    .TRUTH  (TT_OR2),
    .SETTLE (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit       m_busy, m_done, m_pass, m_ffv, m_over;
  int       m_err, m_cnt;
  bit [1:0] m_ffvec;

  function automatic bit gate_y(int g, bit [1:0] v);
    case (g)
      0:       return |v;
      1:       return &v;
      2:       return ^v;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic m_reset();
    m_busy = 0; m_done = 0; m_pass = 0; m_ffv = 0;
    m_over = 0; m_err = 0; m_cnt = 0; m_ffvec = 0;
  endtask

  task automatic m_start();
    m_reset();
    m_busy = 1;
  endtask

  task automatic m_vec(bit [1:0] v, bit yv);
    if (yv != (v != 0)) begin
      m_err++;
      if (!m_ffv) begin
        m_ffv = 1;
        m_ffvec = v;
      end
    end
    m_cnt++;
    if (m_cnt == 4) begin
      m_busy = 0;
      m_done = 1;
      m_pass = (m_err == 0);
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".busy"}, int'(bus.busy), int'(m_busy));
    chk({tag, ".done"}, int'(bus.done), int'(m_done));
    chk({tag, ".pass"}, int'(bus.pass), int'(m_pass));
    chk({tag, ".err"}, int'(bus.err_count), m_err);
    chk({tag, ".ffv"}, int'(bus.first_fail_valid), int'(m_ffv));
    chk({tag, ".ffvec"}, int'(bus.first_fail_vec), int'(m_ffvec));
    chk({tag, ".over"}, int'(bus.overrun), int'(m_over));
  endtask

  // Called at a negedge; returns at a later negedge.
  task automatic do_start(bit with_sv);
    bus.start = 1;
    bus.stim_valid = with_sv;
    bus.stim = 2'($urandom_range(0, 3));
    @(negedge clk);
    bus.start = 0;
    bus.stim_valid = 0;
    m_start();
  endtask

  // y only holds the answer in the cycle the checker should sample it.
  task automatic apply(bit [1:0] v, bit yv, bit dup);
    bus.stim_valid = 1;
    bus.stim = v;
    @(negedge clk);
    bus.stim_valid = dup;
    bus.y = ~yv;
    @(negedge clk);
    bus.stim_valid = 0;
    bus.y = yv;
    @(negedge clk);
    bus.y = ~yv;
    @(negedge clk);
    m_vec(v, yv);
    if (dup) m_over = 1;
  endtask

  initial begin
    bus.start = 0;
    bus.stim_valid = 0;
    bus.stim = 0;
    bus.y = 0;
    m_reset();
    #3;
    chk_all("reset");
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    do_start(0);
    chk_all("or_armed");
    for (int v = 0; v < 4; v++) begin
      apply(2'(v), gate_y(0, 2'(v)), 0);
      if (v == 2) chk_all("or_3vec");
    end
    chk_all("or_done");

    do_start(0);
    for (int v = 0; v < 4; v++) apply(2'(v), gate_y(1, 2'(v)), 0);
    chk_all("and_done");
    chk("and_err2", int'(bus.err_count), 2);
    chk("and_ffvec01", int'(bus.first_fail_vec), 1);

    do_start(0);
    apply(2'd0, 1'b0, 1);
    chk_all("ovr_first");
    apply(2'd1, 1'b1, 0);
    apply(2'd2, 1'b1, 0);
    chk_all("ovr_3acc");
    apply(2'd3, 1'b1, 0);
    chk_all("ovr_done");

    do_start(0);
    apply(2'd1, 1'b0, 0);
    apply(2'd2, 1'b1, 0);
    chk_all("mid_2vec");
    do_start(0);
    chk_all("mid_restart");
    for (int v = 3; v >= 0; v--) apply(2'(v), gate_y(0, 2'(v)), 0);
    chk_all("mid_full");

    do_start(1);
    chk_all("start_sv_done");
    for (int i = 0; i < 4; i++) begin
      bit [1:0] v = 2'($urandom_range(0, 3));
      apply(v, gate_y(0, v), 0);
      if (i == 2) chk_all("ssv_3vec");
    end
    chk_all("ssv_done");

    do_start(0);
    apply(2'd2, 1'b0, 0);
    bus.stim_valid = 1;
    bus.stim = 2'd3;
    @(negedge clk);
    bus.stim_valid = 0;
    #2 rst = 1;
    #1;
    m_reset();
    chk_all("async_rst");
    @(negedge clk);
    rst = 0;
    bus.stim_valid = 1;
    @(negedge clk);
    bus.stim_valid = 0;
    m_over = 1;
    @(negedge clk);
    chk_all("idle_sv");

    for (int r = 0; r < 8; r++) begin
      int g = $urandom_range(0, 3);
      do_start(0);
      for (int i = 0; i < 4; i++) begin
        bit [1:0] v = 2'($urandom_range(0, 3));
        apply(v, gate_y(g, v), 0);
      end
      chk_all("rand_run");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
